seq_divider: RTL

Multi-cycle restoring integer divider: the inverse of the combinational `Mult` multiplier in the arithmetic chapter. It accepts a `WIDTH`-bit dividend and divisor on a start pulse and produces quotient and remainder one bit per clock. It reports completion with a one-cycle `done` pulse. It is the sequential arithmetic block that multiplier-based designs pair with, and `Mult` products can be fed back through it for round-trip checking.

---
 rtl/seq_divider_if.sv | 24 ++
 rtl/seq_divider.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle for seq_divider.
// master drives requests and reads results; slave is the divider side.
interface seq_divider_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, WIDTH+1 cycle latency.
// Define SIGNED_DIV_EN for two's-complement operands (truncating division).
module seq_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_divider_if.slave bus
);
    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dzo_q, dzo_d;
    logic [WIDTH:0]   shifted, trial;
    logic [WIDTH-1:0] a_mag, b_mag;

`ifdef SIGNED_DIV_EN
    logic neg_quo_q, neg_quo_d;
    logic neg_rem_q, neg_rem_d;

    always_comb begin
        a_mag = bus.dividend[WIDTH-1] ? (~bus.dividend + WIDTH'(1)) : bus.dividend;
        b_mag = bus.divisor[WIDTH-1]  ? (~bus.divisor  + WIDTH'(1)) : bus.divisor;
    end
`else
    always_comb begin
        a_mag = bus.dividend;
        b_mag = bus.divisor;
    end
`endif

    // Next-state, datapath and output logic
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        dsr_d   = dsr_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dzo_d   = dzo_q;
`ifdef SIGNED_DIV_EN
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
`endif
        shifted = {rem_q, dvd_q[WIDTH-1]};
        trial   = shifted - {1'b0, dsr_q};

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    busy_d = 1'b1;
                    cnt_d  = '0;
                    rem_d  = '0;
                    dsr_d  = b_mag;
                    dz_d   = (bus.divisor == '0);
`ifdef SIGNED_DIV_EN
                    neg_quo_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                    neg_rem_d = bus.dividend[WIDTH-1];
`endif
                    if (bus.divisor == '0) begin
                        // Raw dividend is kept so it can be returned as the remainder
                        dvd_d   = bus.dividend;
                        state_d = FIX;
                    end else begin
                        dvd_d   = a_mag;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                // trial[WIDTH] set means the subtraction went negative: restore
                if (trial[WIDTH]) begin
                    rem_d = shifted[WIDTH-1:0];
                end else begin
                    rem_d = trial[WIDTH-1:0];
                end
                dvd_d = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                dzo_d   = dz_q;
                state_d = IDLE;
                if (dz_q) begin
                    quo_d = '1;
                    rmd_d = dvd_q;
                end else begin
`ifdef SIGNED_DIV_EN
                    quo_d = neg_quo_q ? (~dvd_q + WIDTH'(1)) : dvd_q;
                    rmd_d = neg_rem_q ? (~rem_q + WIDTH'(1)) : rem_q;
`else
                    quo_d = dvd_q;
                    rmd_d = rem_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and register bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            rem_q   <= '0;
            dsr_q   <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
            quo_q   <= '0;
            rmd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dzo_q   <= 1'b0;
`ifdef SIGNED_DIV_EN
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            dsr_q   <= dsr_d;
            cnt_q   <= cnt_d;
            dz_q    <= dz_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dzo_q   <= dzo_d;
`ifdef SIGNED_DIV_EN
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

    assign bus.quotient    = quo_q;
    assign bus.remainder   = rmd_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dzo_q;

endmodule
